// File: rtl/zoom_sequencer.sv
// Frame scaler sequencer: walks the destination raster, fetches source pixels (one per output
// pixel, or an FxF block in block-average zoom-out), and emits one destination write per pixel.
module zoom_sequencer #(
  parameter int unsigned SRC_W = 160,
  parameter int unsigned SRC_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_pulse,
  input  logic [1:0]  algorithm_select,
  input  logic [2:0]  zoom_level,
  output logic        src_rd_en,
  output logic [14:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        dst_we,
  output logic [18:0] dst_addr,
  output logic [7:0]  dst_wdata,
  input  logic        dst_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [9:0]  dst_width,
  output logic [8:0]  dst_height
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

  state_e      state_q, state_d;
  logic        cfg_out_q, cfg_out_d;
  logic [1:0]  cfg_k_q, cfg_k_d;
  logic [1:0]  cfg_sub_k_q, cfg_sub_k_d;
  logic [9:0]  dx_q, dx_d;
  logic [8:0]  dy_q, dy_d;
  logic [1:0]  sub_x_q, sub_x_d;
  logic [1:0]  sub_y_q, sub_y_d;
  logic [11:0] acc_q, acc_d;
  logic [18:0] dst_addr_q, dst_addr_d;
  logic [7:0]  dst_wdata_q, dst_wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [9:0]  width_q, width_d;
  logic [8:0]  height_q, height_d;

  logic        start_bad;
  logic [1:0]  k_new;
  logic [9:0]  w_new;
  logic [8:0]  h_new;
  logic [1:0]  sub_max;
  logic        first_sub, last_sub, last_col, last_row;
  logic [14:0] sx, sy;

  // Start-time decode of the requested zoom.
  always_comb begin
    k_new = 2'd0;
    w_new = 10'(SRC_W);
    h_new = 9'(SRC_H);
    case (zoom_level)
      3'd0: begin k_new = 2'd2; w_new = 10'(SRC_W >> 2); h_new = 9'(SRC_H >> 2); end
      3'd1: begin k_new = 2'd1; w_new = 10'(SRC_W >> 1); h_new = 9'(SRC_H >> 1); end
      3'd3: begin k_new = 2'd1; w_new = 10'(SRC_W << 1); h_new = 9'(SRC_H << 1); end
      3'd4: begin k_new = 2'd2; w_new = 10'(SRC_W << 2); h_new = 9'(SRC_H << 2); end
      default: ;
    endcase
  end

  assign start_bad = (zoom_level > 3'd4) || algorithm_select[1];

  // Sub-sample grid is 1x1 except for block-average zoom-out.
  assign sub_max   = 2'((3'd1 << cfg_sub_k_q) - 3'd1);
  assign first_sub = (sub_x_q == 2'd0) && (sub_y_q == 2'd0);
  assign last_sub  = (sub_x_q == sub_max) && (sub_y_q == sub_max);
  assign last_col  = (dx_q == width_q - 10'd1);
  assign last_row  = (dy_q == height_q - 9'd1);

  assign sx = cfg_out_q ? ((15'(dx_q) << cfg_k_q) + 15'(sub_x_q)) : (15'(dx_q) >> cfg_k_q);
  assign sy = cfg_out_q ? ((15'(dy_q) << cfg_k_q) + 15'(sub_y_q)) : (15'(dy_q) >> cfg_k_q);

  always_comb begin
    state_d     = state_q;
    cfg_out_d   = cfg_out_q;
    cfg_k_d     = cfg_k_q;
    cfg_sub_k_d = cfg_sub_k_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sub_x_d     = sub_x_q;
    sub_y_d     = sub_y_q;
    acc_d       = acc_q;
    dst_addr_d  = dst_addr_q;
    dst_wdata_d = dst_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    width_d     = width_q;
    height_d    = height_q;
    unique case (state_q)
      StIdle: begin
        if (start_pulse) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          if (start_bad) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            cfg_out_d   = (zoom_level < 3'd2);
            cfg_k_d     = k_new;
            cfg_sub_k_d = ((algorithm_select == 2'b01) && (zoom_level < 3'd2)) ? k_new : 2'd0;
            width_d     = w_new;
            height_d    = h_new;
            dx_d        = '0;
            dy_d        = '0;
            sub_x_d     = '0;
            sub_y_d     = '0;
            acc_d       = '0;
            dst_addr_d  = '0;
            state_d     = StRd;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        acc_d = first_sub ? {4'd0, src_rdata} : acc_q + {4'd0, src_rdata};
        if (last_sub) begin
          sub_x_d     = '0;
          sub_y_d     = '0;
          dst_wdata_d = 8'(acc_d >> {cfg_sub_k_q, 1'b0});
          state_d     = StWr;
        end else begin
          if (sub_x_q == sub_max) begin
            sub_x_d = '0;
            sub_y_d = sub_y_q + 2'd1;
          end else begin
            sub_x_d = sub_x_q + 2'd1;
          end
          state_d = StRd;
        end
      end
      StWr: begin
        if (dst_ready) begin
          dst_addr_d = dst_addr_q + 19'd1;
          state_d    = StRd;
          if (last_col) begin
            dx_d = '0;
            if (last_row) begin
              dy_d    = '0;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              dy_d = dy_q + 9'd1;
            end
          end else begin
            dx_d = dx_q + 10'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cfg_out_q   <= 1'b0;
      cfg_k_q     <= '0;
      cfg_sub_k_q <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sub_x_q     <= '0;
      sub_y_q     <= '0;
      acc_q       <= '0;
      dst_addr_q  <= '0;
      dst_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      width_q     <= 10'(SRC_W);
      height_q    <= 9'(SRC_H);
    end else begin
      state_q     <= state_d;
      cfg_out_q   <= cfg_out_d;
      cfg_k_q     <= cfg_k_d;
      cfg_sub_k_q <= cfg_sub_k_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sub_x_q     <= sub_x_d;
      sub_y_q     <= sub_y_d;
      acc_q       <= acc_d;
      dst_addr_q  <= dst_addr_d;
      dst_wdata_q <= dst_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      width_q     <= width_d;
      height_q    <= height_d;
    end
  end

  assign src_rd_en  = (state_q == StRd);
  assign src_addr   = sy * 15'(SRC_W) + sx;
  assign dst_we     = (state_q == StWr);
  assign dst_addr   = dst_addr_q;
  assign dst_wdata  = dst_wdata_q;
  assign busy       = (state_q == StRd) || (state_q == StCap) || (state_q == StWr);
  assign done       = done_q;
  assign error      = error_q;
  assign dst_width  = width_q;
  assign dst_height = height_q;

endmodule

// File: tb/tb_zoom_sequencer.sv
// Randomised self-checking bench for zoom_sequencer against a behavioural image-scaling model.
module tb_zoom_sequencer;
  localparam int W = 20;
  localparam int H = 12;
  localparam int MAXP = W * H * 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_pulse = 1'b0;
  logic [1:0]  algorithm_select = 2'd0;
  logic [2:0]  zoom_level = 3'd2;
  logic [7:0]  src_rdata = 8'd0;
  logic        dst_ready = 1'b1;
  logic        src_rd_en, dst_we, busy, done, error;
  logic [14:0] src_addr;
  logic [18:0] dst_addr;
  logic [7:0]  dst_wdata;
  logic [9:0]  dst_width;
  logic [8:0]  dst_height;

  int total = 0;
  int bad = 0;

  logic [7:0]  src_mem[W*H];
  int          dst_cap[MAXP];
  int          rd_log[16];
  int          wr_cnt, rd_cnt, seq_err, stall_err;
  bit          prev_stall;
  logic [18:0] prev_addr;
  logic [7:0]  prev_data;

  zoom_sequencer #(.SRC_W(W), .SRC_H(H)) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .algorithm_select(algorithm_select),
    .zoom_level(zoom_level), .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_ready(dst_ready),
    .busy(busy), .done(done), .error(error), .dst_width(dst_width), .dst_height(dst_height)
  );

  always #5 clk = ~clk;

  // Source memory: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    src_rdata <= (src_rd_en && src_addr < 15'(W * H)) ? src_mem[src_addr] : 8'($urandom);

  always @(negedge clk) begin
    if (!reset) begin
      if (src_rd_en) begin
        if (rd_cnt < 16) rd_log[rd_cnt] = int'(src_addr);
        rd_cnt++;
      end
      if (prev_stall && (!dst_we || dst_addr !== prev_addr || dst_wdata !== prev_data)) stall_err++;
      prev_stall = dst_we && !dst_ready;
      prev_addr  = dst_addr;
      prev_data  = dst_wdata;
      if (dst_we && dst_ready) begin
        if (dst_addr !== 19'(wr_cnt)) seq_err++;
        if (int'(dst_addr) < MAXP) dst_cap[dst_addr] = int'(dst_wdata);
        wr_cnt++;
      end
    end
  end

  function automatic int kof(int zoom);
    return (zoom == 0 || zoom == 4) ? 2 : (zoom == 2) ? 0 : 1;
  endfunction

  function automatic int exp_w(int zoom);
    return (zoom < 2) ? (W >> kof(zoom)) : (W << kof(zoom));
  endfunction

  function automatic int exp_h(int zoom);
    return (zoom < 2) ? (H >> kof(zoom)) : (H << kof(zoom));
  endfunction

  function automatic int reads_per(int alg, int zoom);
    return (alg == 1 && zoom < 2) ? (1 << (2 * kof(zoom))) : 1;
  endfunction

  function automatic int exp_pix(int alg, int zoom, int dx, int dy);
    int k, f, sum;
    k = kof(zoom);
    f = 1 << k;
    if (zoom >= 2) return int'(src_mem[(dy >> k) * W + (dx >> k)]);
    if (alg == 0) return int'(src_mem[(dy * f) * W + dx * f]);
    sum = 0;
    for (int y = 0; y < f; y++)
      for (int x = 0; x < f; x++)
        sum += int'(src_mem[(dy * f + y) * W + dx * f + x]);
    return sum / (f * f);
  endfunction

  function automatic int image_errors(int alg, int zoom);
    int n;
    n = 0;
    for (int dy = 0; dy < exp_h(zoom); dy++)
      for (int dx = 0; dx < exp_w(zoom); dx++)
        if (dst_cap[dy * exp_w(zoom) + dx] != exp_pix(alg, zoom, dx, dy)) n++;
    return n;
  endfunction

  task automatic clear_capture();
    wr_cnt = 0; rd_cnt = 0; seq_err = 0; stall_err = 0; prev_stall = 0;
    foreach (dst_cap[i]) dst_cap[i] = -1;
    foreach (rd_log[i]) rd_log[i] = -1;
  endtask

  task automatic fill_src();
    foreach (src_mem[i]) src_mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input int alg, input int zoom, input bit rand_ready,
                           input bit extra_start, output int cyc, output bit to);
    clear_capture();
    @(posedge clk); #1;
    algorithm_select = 2'(alg);
    zoom_level = 3'(zoom);
    start_pulse = 1'b1;
    cyc = 0;
    to = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start_pulse = 1'b0;
      if (rand_ready) dst_ready = ($urandom % 3) != 0;
      if (extra_start && cyc == 6) begin
        start_pulse = 1'b1;
        algorithm_select = 2'($urandom);
        zoom_level = 3'($urandom);
      end
      if (done) break;
      if (cyc > 40000) begin to = 1; break; end
    end
    start_pulse = 1'b0;
    dst_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (src_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got %b want 0", src_rd_en); end
    total++; if (dst_we !== 1'b0) begin bad++; $display("FAIL rst_we got %b want 0", dst_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got %b want 0", error); end
    total++; if (src_addr !== 15'd0) begin bad++; $display("FAIL rst_src_addr got %0d want 0", src_addr); end
    total++; if (dst_addr !== 19'd0) begin bad++; $display("FAIL rst_dst_addr got %0d want 0", dst_addr); end
    total++; if (dst_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata got %0d want 0", dst_wdata); end
    total++; if (dst_width !== 10'(W)) begin bad++; $display("FAIL rst_width got %0d want %0d", dst_width, W); end
    total++; if (dst_height !== 9'(H)) begin bad++; $display("FAIL rst_height got %0d want %0d", dst_height, H); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || src_rd_en !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset busy=%b rd=%b want 0 0", busy, src_rd_en);
    end
  endtask

  task automatic test_invalid();
    int cfg_a[2] = '{0, 2};
    int cfg_z[2] = '{6, 2};
    bit to;
    for (int i = 0; i < 2; i++) begin
      clear_capture();
      @(posedge clk); #1;
      algorithm_select = 2'(cfg_a[i]);
      zoom_level = 3'(cfg_z[i]);
      start_pulse = 1'b1;
      @(posedge clk); #1;
      start_pulse = 1'b0;
      total++; if (error !== 1'b1 || done !== 1'b1) begin
        bad++; $display("FAIL invalid%0d_flags error=%b done=%b want 1 1", i, error, done);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL invalid%0d_busy got %b want 0", i, busy); end
      repeat (4) @(posedge clk);
      #1;
      total++; if (rd_cnt != 0 || wr_cnt != 0) begin
        bad++; $display("FAIL invalid%0d_traffic reads=%0d writes=%0d want 0 0", i, rd_cnt, wr_cnt);
      end
    end
    clear_capture();
    @(posedge clk); #1;
    algorithm_select = 2'd0;
    zoom_level = 3'd0;
    start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    total++; if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL valid_after_invalid error=%b done=%b busy=%b want 0 0 1", error, done, busy);
    end
    to = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (done) begin to = 0; break; end
    end
    total++; if (to || wr_cnt != 15) begin
      bad++; $display("FAIL valid_after_invalid_frame timeout=%0d writes=%0d want 0 15", to, wr_cnt);
    end
  endtask

  task automatic test_scaling();
    int cfg_a[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int cfg_z[8] = '{2, 3, 4, 1, 0, 1, 0, 3};
    int cyc, n, r, e;
    bit to;
    for (int i = 0; i < 8; i++) begin
      fill_src();
      run_frame(cfg_a[i], cfg_z[i], 1'b0, 1'b0, cyc, to);
      n = exp_w(cfg_z[i]) * exp_h(cfg_z[i]);
      r = reads_per(cfg_a[i], cfg_z[i]);
      total++; if (to) begin bad++; $display("FAIL scale%0d_timeout got timeout want done", i); end
      total++; if (dst_width !== 10'(exp_w(cfg_z[i])) || dst_height !== 9'(exp_h(cfg_z[i]))) begin
        bad++; $display("FAIL scale%0d_dims got %0dx%0d want %0dx%0d", i, dst_width, dst_height,
                        exp_w(cfg_z[i]), exp_h(cfg_z[i]));
      end
      total++; if (wr_cnt != n || rd_cnt != n * r) begin
        bad++; $display("FAIL scale%0d_counts writes=%0d reads=%0d want %0d %0d", i, wr_cnt, rd_cnt,
                        n, n * r);
      end
      total++; if (cyc != n * (2 * r + 1) + 1) begin
        bad++; $display("FAIL scale%0d_latency got %0d want %0d", i, cyc, n * (2 * r + 1) + 1);
      end
      e = image_errors(cfg_a[i], cfg_z[i]);
      total++; if (e != 0 || seq_err != 0) begin
        bad++; $display("FAIL scale%0d_image pixel_errs=%0d addr_errs=%0d want 0 0", i, e, seq_err);
      end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b1 || error !== 1'b0) begin
        bad++; $display("FAIL scale%0d_status busy=%b done=%b error=%b want 0 1 0", i, busy, done, error);
      end
    end
  endtask

  task automatic test_block_average();
    int cyc, e;
    bit to;
    fill_src();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        src_mem[y * W + x] = 8'(y * 4 + x);
        src_mem[y * W + 4 + x] = 8'd255;
      end
    run_frame(1, 0, 1'b0, 1'b0, cyc, to);
    total++; if (to) begin bad++; $display("FAIL avg_timeout got timeout want done"); end
    total++; if (dst_cap[0] != 7) begin bad++; $display("FAIL avg_first got %0d want 7", dst_cap[0]); end
    total++; if (dst_cap[1] != 255) begin bad++; $display("FAIL avg_sat got %0d want 255", dst_cap[1]); end
    e = 0;
    for (int i = 0; i < 16; i++) if (rd_log[i] != (i / 4) * W + (i % 4)) e++;
    total++; if (e != 0) begin bad++; $display("FAIL avg_read_order bad_reads=%0d want 0", e); end
    total++; if (rd_cnt != 16 * 15 || wr_cnt != 15) begin
      bad++; $display("FAIL avg_counts reads=%0d writes=%0d want 240 15", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, e;
    bit to;
    fill_src();
    run_frame(0, 3, 1'b1, 1'b1, cyc, to);
    e = image_errors(0, 3);
    total++; if (to) begin bad++; $display("FAIL stall_timeout got timeout want done"); end
    total++; if (e != 0 || seq_err != 0) begin
      bad++; $display("FAIL stall_image pixel_errs=%0d addr_errs=%0d want 0 0", e, seq_err);
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
    repeat (6) @(posedge clk);
    #1;
    total++; if (wr_cnt != 960 || busy !== 1'b0 || error !== 1'b0 || dst_width !== 10'd40) begin
      bad++; $display("FAIL second_start writes=%0d busy=%b error=%b width=%0d want 960 0 0 40",
                      wr_cnt, busy, error, dst_width);
    end
  endtask

  task automatic test_reset_midframe();
    int cyc, e;
    bit to;
    fill_src();
    clear_capture();
    @(posedge clk); #1;
    algorithm_select = 2'd0;
    zoom_level = 3'd4;
    start_pulse = 1'b1;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    to = 1;
    for (int c = 0; c < 5000; c++) begin
      if (wr_cnt >= 500) begin to = 0; break; end
      @(posedge clk); #1;
    end
    total++; if (to) begin bad++; $display("FAIL midreset_reach got %0d writes want 500", wr_cnt); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (src_rd_en !== 1'b0 || dst_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                 error !== 1'b0) begin
      bad++; $display("FAIL midreset_ctrl rd=%b we=%b busy=%b done=%b err=%b want all 0",
                      src_rd_en, dst_we, busy, done, error);
    end
    total++; if (dst_addr !== 19'd0 || dst_wdata !== 8'd0 || src_addr !== 15'd0 ||
                 dst_width !== 10'(W)) begin
      bad++; $display("FAIL midreset_data daddr=%0d wdata=%0d saddr=%0d width=%0d want 0 0 0 %0d",
                      dst_addr, dst_wdata, src_addr, dst_width, W);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    fill_src();
    run_frame(0, 4, 1'b0, 1'b0, cyc, to);
    e = image_errors(0, 4);
    total++; if (to || wr_cnt != 3840) begin
      bad++; $display("FAIL midreset_frame timeout=%0d writes=%0d want 0 3840", to, wr_cnt);
    end
    total++; if (e != 0 || seq_err != 0) begin
      bad++; $display("FAIL midreset_image pixel_errs=%0d addr_errs=%0d want 0 0", e, seq_err);
    end
  endtask

  initial begin
    clear_capture();
    fill_src();
    repeat (3) @(posedge clk);
    test_reset();
    test_invalid();
    test_scaling();
    test_block_average();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
